// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stall-cause
// encodings, the zero register specifier and the default watchdog limit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LUSTALL = 2'd1,
    ST_ISTALL  = 2'd2,
    ST_DSTALL  = 2'd3
  } ctrl_state_e;

  // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
  localparam logic [31:0] REG_ZERO = 32'd0;

  localparam int STALL_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  lu
);

  logic [REG_ADDR_W-1:0] zero_reg;
  assign zero_reg = REG_ZERO[REG_ADDR_W-1:0];

  assign lu = ex_memread && (ex_rt != zero_reg) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Optional
// performance counters are built when PIPE_HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W    = 5,
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF,
  parameter int TO_CNT_W      = 11,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_branch_taken,
  input  logic                  icache_stall,
  input  logic                  dcache_stall,
  output logic                  pc_write,
  output logic                  ifid_hold,
  output logic                  if_flush,
  output logic                  idex_bubble,
  output logic                  idex_hold,
  output logic                  exmem_hold,
  output logic                  memwb_bubble,
  output logic [1:0]            ctrl_state,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      perf_istall,
  output logic [CNT_W-1:0]      perf_dstall,
  output logic [CNT_W-1:0]      perf_lustall,
  output logic [CNT_W-1:0]      perf_flush
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(STALL_TIMEOUT - 1);

  ctrl_state_e         state_q, state_d;
  logic                lu;
  logic [TO_CNT_W-1:0] to_cnt;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .lu         (lu)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_RUN;
    if (dcache_stall)      state_d = ST_DSTALL;
    else if (icache_stall) state_d = ST_ISTALL;
    else if (lu)           state_d = ST_LUSTALL;
  end

  // Zero-latency controls; a taken branch loses to any stall so it re-resolves later.
  always_comb begin
    pc_write     = 1'b0;
    ifid_hold    = 1'b0;
    if_flush     = 1'b0;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst) begin
      if (dcache_stall) begin
        ifid_hold    = 1'b1;
        idex_hold    = 1'b1;
        exmem_hold   = 1'b1;
        memwb_bubble = 1'b1;
      end else if (icache_stall || lu) begin
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end else if (id_branch_taken) begin
        pc_write = 1'b1;
        if_flush = 1'b1;
      end else begin
        pc_write = 1'b1;
      end
    end
  end

  assign ctrl_state = state_q;

  // Watchdog counts cycles spent in one unchanged stall cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if ((state_d != state_q) || (state_q == ST_RUN)) to_cnt <= '0;
      else if (to_cnt != '1)                           to_cnt <= to_cnt + TO_CNT_W'(1);
      if ((state_d == state_q) && (state_q != ST_RUN) && (to_cnt == TO_LIMIT))
        stall_timeout <= 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_istall  <= '0;
      perf_dstall  <= '0;
      perf_lustall <= '0;
      perf_flush   <= '0;
    end else begin
      if ((state_q == ST_ISTALL) && (perf_istall != '1))   perf_istall  <= perf_istall + CNT_W'(1);
      if ((state_q == ST_DSTALL) && (perf_dstall != '1))   perf_dstall  <= perf_dstall + CNT_W'(1);
      if ((state_q == ST_LUSTALL) && (perf_lustall != '1)) perf_lustall <= perf_lustall + CNT_W'(1);
      if (if_flush && (perf_flush != '1))                  perf_flush   <= perf_flush + CNT_W'(1);
    end
  end
`else
  assign perf_istall  = '0;
  assign perf_dstall  = '0;
  assign perf_lustall = '0;
  assign perf_flush   = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline with I-cache and D-cache.
- Drives the PC write enable and the hold, flush and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards, arbitrates them against cache-miss stalls and ID-stage branch redirects, and records the active stall cause.
- Raises a sticky watchdog error on runaway stalls.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- STALL_TIMEOUT, 1024, consecutive same-cause stall cycles that set stall_timeout.
- TO_CNT_W, 11, watchdog counter width; must satisfy 2^TO_CNT_W > STALL_TIMEOUT.
- CNT_W, 32, performance-counter width (optional feature only).

Ports:
- clk, input, 1, clock; FSM and counters update on posedge; pipeline registers sample outputs on negedge.
- rst, input, 1, reset, asynchronous, active-high.
- id_rs, input, REG_ADDR_W, rs of the instruction in ID.
- id_rt, input, REG_ADDR_W, rt of the instruction in ID.
- id_uses_rt, input, 1, ID instruction reads rt.
- ex_memread, input, 1, EX instruction is a load.
- ex_rt, input, REG_ADDR_W, load destination in EX.
- id_branch_taken, input, 1, branch/jump resolved taken in ID.
- icache_stall, input, 1, I-cache miss in progress (level).
- dcache_stall, input, 1, D-cache miss in progress (level).
- pc_write, output, 1, 1 = PC updates.
- ifid_hold, output, 1, 1 = IF/ID keeps contents; takes priority over if_flush inside IF/ID.
- if_flush, output, 1, 1 = IF/ID instruction zeroed (NOP), PC still captured.
- idex_bubble, output, 1, zero control fields entering ID/EX.
- idex_hold, output, 1, ID/EX keeps contents.
- exmem_hold, output, 1, EX/MEM keeps contents.
- memwb_bubble, output, 1, zero control fields entering MEM/WB.
- ctrl_state, output, 2, registered stall cause: 0 RUN, 1 LUSTALL, 2 ISTALL, 3 DSTALL.
- stall_timeout, output, 1, sticky watchdog error.

Behaviour:
- Load-use hit (lu) = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
- Control outputs are combinational from inputs, zero latency. Priority, first match wins:
  1. rst: all control outputs 0, including pc_write = 0.
  2. dcache_stall: pc_write 0, ifid_hold 1, idex_hold 1, exmem_hold 1, memwb_bubble 1; if_flush 0, idex_bubble 0.
  3. icache_stall: pc_write 0, ifid_hold 1, idex_bubble 1; everything else 0. EX/MEM/WB keep draining.
  4. lu: pc_write 0, ifid_hold 1, idex_bubble 1.
  5. id_branch_taken: pc_write 1, if_flush 1.
  6. Otherwise: pc_write 1, all others 0.
- Invariants:
  - ifid_hold and if_flush are never both 1.
  - idex_hold and idex_bubble are never both 1.
  - A taken branch coincident with lu or any cache stall is not flushed that cycle. The branch stays in ID and re-resolves after the stall.
- FSM (posedge, asynchronous reset to RUN):
  - next = DSTALL if dcache_stall, else ISTALL if icache_stall, else LUSTALL if lu, else RUN.
  - ctrl_state = current state.
- Watchdog:
  - to_cnt clears on reset, on any state change, and while in RUN.
  - Otherwise it increments each cycle, saturating at all-ones.
  - When to_cnt reaches STALL_TIMEOUT-1 while the state is unchanged, stall_timeout sets on the next edge.
  - stall_timeout stays set until rst.
- Reset mid-stall: state returns to RUN, to_cnt and stall_timeout clear, and outputs follow priority 1 immediately. No pending stall survives reset.
- D-miss ending while an I-miss is still active: the FSM moves DSTALL -> ISTALL in one cycle and the watchdog restarts.

Optional Feature:
- Macro PIPE_HAZARD_PERF_CNT_EN.
- Defined:
  - Output ports perf_istall, perf_dstall, perf_lustall and perf_flush (each CNT_W wide) are present.
  - They count cycles in ISTALL, DSTALL and LUSTALL respectively, and cycles where if_flush = 1.
  - All saturate at all-ones and clear on rst.
- Undefined: the four ports are present but tied to 0, and no counter flops are generated.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - ctrl_state encodings (ST_RUN, ST_LUSTALL, ST_ISTALL, ST_DSTALL);
  - the REG_ZERO constant;
  - the default STALL_TIMEOUT.
- One sub-module, hazard_detect: the combinational lu comparator. It is reused later by forwarding-unit verification.

Test Plan:
- ex_memread=1, ex_rt=8, id_rs=8 -> pc_write=0, ifid_hold=1, idex_bubble=1, ctrl_state=1 next cycle. Same stimulus with ex_rt=0 -> pc_write=1, no stall.
- id_branch_taken=1, no hazard -> if_flush=1, pc_write=1, ifid_hold=0. With lu also true -> if_flush=0, ifid_hold=1.
- icache_stall 5 cycles, then dcache_stall for cycles 3-7 -> state sequence ISTALL, ISTALL, DSTALL x5, RUN. exmem_hold=1 only in the DSTALL cycles.
- dcache_stall held for STALL_TIMEOUT+2 cycles (STALL_TIMEOUT=16 in bench) -> stall_timeout rises after 16 cycles and stays 1 after the stall ends, until rst.
- rst pulsed asynchronously mid-DSTALL -> ctrl_state=0, all outputs 0 and stall_timeout=0 immediately. After release with no stimulus, pc_write=1.
- With PIPE_HAZARD_PERF_CNT_EN: 3 ISTALL cycles, 2 lu cycles and 4 flushes -> perf_istall=3, perf_lustall=2, perf_flush=4, perf_dstall=0.
